// File: rtl/mem_dma.sv
// Block-transfer requester for a single-port word memory: word copy (src->dst)
// or constant fill (dst) of len words. All outputs come straight from registers.
module mem_dma #(
  parameter int AW    = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [CNT_W-1:0] len,
  input  logic [AW-1:0]    fill_val,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [AW-1:0]    mem_wd,
  input  logic [AW-1:0]    mem_rd,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t             state;
  logic [AW-1:0]      src_l;
  logic [AW-1:0]      dst_l;
  logic [CNT_W-1:0]   len_l;
  logic               mode_l;
  logic [AW-1:0]      fill_l;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   idx_nx;
  logic               last;

  assign idx_nx    = idx + CNT_W'(1);
  assign last      = (idx == len_l - CNT_W'(1));
  assign dbg_state = state;

  // Outputs are computed one edge ahead so that mem_a/mem_we/mem_wd line up
  // with the state they belong to. In copy mode mem_wd doubles as the read buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_l    <= '0;
      dst_l    <= '0;
      len_l    <= '0;
      mode_l   <= 1'b0;
      fill_l   <= '0;
      idx      <= '0;
      xfer_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_wd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          mem_we <= 1'b0;
          mem_a  <= '0;
          mem_wd <= '0;
          if (start) begin
            src_l    <= src;
            dst_l    <= dst;
            len_l    <= len;
            mode_l   <= mode;
            fill_l   <= fill_val;
            idx      <= '0;
            xfer_cnt <= '0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state  <= WR;
              busy   <= 1'b1;
              mem_we <= 1'b1;
              mem_a  <= dst;
              mem_wd <= fill_val;
            end else begin
              state <= RD;
              busy  <= 1'b1;
              mem_a <= src;
            end
          end
        end
        RD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            mem_a <= '0;
          end else begin
            state  <= WR;
            mem_we <= 1'b1;
            mem_a  <= dst_l + AW'(idx);
            mem_wd <= mem_rd;
          end
        end
        WR: begin
          // The write presented this cycle commits at this edge, aborted or not.
          idx      <= idx_nx;
          xfer_cnt <= xfer_cnt + CNT_W'(1);
          if (abort || last) begin
            state  <= abort ? IDLE : DONE;
            done   <= !abort;
            busy   <= 1'b0;
            mem_we <= 1'b0;
            mem_a  <= '0;
            mem_wd <= '0;
          end else if (mode_l) begin
            mem_a  <= dst_l + AW'(idx_nx);
            mem_wd <= fill_l;
          end else begin
            state  <= RD;
            mem_we <= 1'b0;
            mem_a  <= src_l + AW'(idx_nx);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
